gray_conv_sched: RTL and testbench
==================================

GRAY_CONV_SCHED -- requirements
Module: gray_conv_sched

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one Gray converter (2..8).
REQ-002 Parameter DW, default 8, data width; fixed at 8 to match the converter datapath.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 req_i  input  N_REQ  per-requester request; held high until matching req_ack_o pulse.
REQ-006 req_data_i  input  N_REQ*DW  packed request data; slice k = bits [k*DW +: DW], stable while req_i[k] high.
REQ-007 req_ack_o  output  N_REQ  one-hot, one-cycle pulse; request k accepted.
REQ-008 conv_en_o  output  3  converter enable code: 3'b100 in CONV, 3'b000 otherwise.
REQ-009 conv_data_o  output  DW  operand to converter: latched data in CONV, 8'h00 otherwise.
REQ-010 conv_result_i  input  DW  combinational converter result.
REQ-011 rsp_valid_o  output  1  response valid.
REQ-012 rsp_ready_i  input  1  response consumer ready.
REQ-013 rsp_id_o  output  3  index of requester owning the response.
REQ-014 rsp_data_o  output  DW  captured Gray result.
REQ-015 busy_o  output  1  high in any state other than IDLE.

Function
REQ-016 FSM SHALL have exactly three states: IDLE, CONV, RESP.
REQ-017 IDLE: if req_i != 0, grant one requester, latch its data and index, pulse req_ack_o[grant], go to CONV; otherwise stay.
REQ-018 Arbitration SHALL be round-robin: search starts at ptr, ptr wraps N_REQ-1 -> 0.
REQ-019 CONV SHALL last exactly one cycle; at its end conv_result_i is registered into rsp_data_o, then go to RESP.
REQ-020 RESP: rsp_valid_o = 1; rsp_id_o and rsp_data_o SHALL stay stable until rsp_valid_o && rsp_ready_i.
REQ-021 On RESP handshake: ptr <= (rsp_id_o + 1) mod N_REQ, go to IDLE.
REQ-022 Latency: ack in cycle T, CONV in cycle T+1, rsp_valid_o first high in cycle T+2; peak throughput one result per 3 cycles.
REQ-023 req_i edges in CONV or RESP SHALL be ignored; no ack outside IDLE.
REQ-024 A request deasserted before its ack SHALL be dropped without side effects.
REQ-025 rsp_ready_i high outside RESP SHALL have no effect.
REQ-026 rsp_data_o retains its last value after handshake; only rsp_valid_o qualifies it.

Reset
REQ-027 rst_i high SHALL immediately force: state IDLE, ptr 0, req_ack_o 0, conv_en_o 3'b000, conv_data_o 0, rsp_valid_o 0, rsp_id_o 0, rsp_data_o 0, busy_o 0.
REQ-028 Reset mid-transaction SHALL discard the in-flight grant; the requester must re-request.
REQ-029 First grant after reset SHALL search from requester 0.

Configuration
REQ-030 Macro GRAY_SCHED_PRIO0_EN: when defined, req_i[0] wins whenever asserted in IDLE; remaining requesters arbitrate round-robin among themselves.
REQ-031 Without GRAY_SCHED_PRIO0_EN, all requesters are pure round-robin per REQ-018.

Verification
REQ-032 Single: req_i=4'b0010, slice1=8'h05 -> ack 4'b0010 at T, conv_en_o 3'b100 / conv_data_o 8'h05 at T+1, rsp_valid_o at T+2 with id 1, data 8'h07.
REQ-033 All four requesting, data 8'hFF/8'h80/8'h00/8'h2A, rsp_ready_i=1 -> grant order 0,1,2,3; data 8'h80, 8'hC0, 8'h00, 8'h3F.
REQ-034 Backpressure: rsp_ready_i=0 for 5 cycles -> rsp_valid_o, id, data stable; no ack on pending requests; release -> next grant next cycle.
REQ-035 Reset asserted during CONV -> all outputs reset values same cycle; resume with req_i=4'b0001, data 8'h03 -> response 8'h02.
REQ-036 With GRAY_SCHED_PRIO0_EN, req_i=4'b1111 held -> requester 0 granted every transaction; without, grants rotate 0,1,2,3,0.

Source files
------------

// File: rtl/gray_conv_sched.sv
// Round-robin scheduler that time-shares one external binary-to-Gray converter among N_REQ requesters.
// Optional build macro GRAY_SCHED_PRIO0_EN gives requester 0 absolute priority in IDLE.
module gray_conv_sched #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DW    = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N_REQ-1:0]   req_i,
    input  logic [N_REQ*DW-1:0] req_data_i,
    output logic [N_REQ-1:0]   req_ack_o,
    output logic [2:0]         conv_en_o,
    output logic [DW-1:0]      conv_data_o,
    input  logic [DW-1:0]      conv_result_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [2:0]         rsp_id_o,
    output logic [DW-1:0]      rsp_data_o,
    output logic               busy_o
);

    typedef enum logic [1:0] {StIdle, StConv, StResp} state_e;

    state_e        state_q, state_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [2:0]    idx_q, idx_d;
    logic [DW-1:0] data_q, data_d;
    logic [2:0]    rsp_id_q, rsp_id_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;

    logic [7:0]    req_ext;
    logic [DW-1:0] data_arr [8];
    logic [3:0]    cand;
    logic          rr_vld;
    logic [2:0]    rr_idx;
    logic          grant_vld;
    logic [2:0]    grant_idx;
    logic          ack_en;

    // Widen requests/data to 8 entries so a 3-bit index always addresses them exactly.
    always_comb begin
        req_ext = '0;
        req_ext[N_REQ-1:0] = req_i;
        for (int k = 0; k < 8; k++) begin
            data_arr[k] = '0;
        end
        for (int k = 0; k < int'(N_REQ); k++) begin
            data_arr[k] = req_data_i[k*DW +: DW];
        end
    end

    // Round-robin search: first requester at or after ptr, wrapping at N_REQ.
    always_comb begin
        rr_vld = 1'b0;
        rr_idx = '0;
        cand   = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            cand = {1'b0, ptr_q} + 4'(i);
            if (cand >= 4'(N_REQ)) begin
                cand = cand - 4'(N_REQ);
            end
            if (!rr_vld && req_ext[cand[2:0]]) begin
                rr_vld = 1'b1;
                rr_idx = cand[2:0];
            end
        end
    end

    always_comb begin
        grant_vld = rr_vld;
        grant_idx = rr_idx;
`ifdef GRAY_SCHED_PRIO0_EN
        if (req_ext[0]) begin
            grant_vld = 1'b1;
            grant_idx = '0;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        data_d     = data_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        unique case (state_q)
            StIdle: begin
                if (grant_vld) begin
                    idx_d   = grant_idx;
                    data_d  = data_arr[grant_idx];
                    state_d = StConv;
                end
            end
            StConv: begin
                rsp_id_d   = idx_q;
                rsp_data_d = conv_result_i;
                state_d    = StResp;
            end
            StResp: begin
                if (rsp_ready_i) begin
                    ptr_d   = (rsp_id_q == 3'(N_REQ - 1)) ? 3'd0 : rsp_id_q + 3'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Ack is combinational from req_i, so it is masked while reset is held.
    always_comb begin
        ack_en = (state_q == StIdle) && grant_vld && !rst_i;
        for (int k = 0; k < int'(N_REQ); k++) begin
            req_ack_o[k] = ack_en && (grant_idx == 3'(k));
        end
        conv_en_o   = (state_q == StConv) ? 3'b100 : 3'b000;
        conv_data_o = (state_q == StConv) ? data_q : '0;
        rsp_valid_o = (state_q == StResp);
        rsp_id_o    = rsp_id_q;
        rsp_data_o  = rsp_data_q;
        busy_o      = (state_q != StIdle);
    end

endmodule

// File: tb/tb_gray_conv_sched.sv
// Directed bench for gray_conv_sched: cycle table plus hand sequences for backpressure,
// reset during CONV and arbitration rotation. The converter is modelled as g = b ^ (b >> 1).
module tb_gray_conv_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [2:0]  conv_en;
    logic [7:0]  conv_data;
    logic [7:0]  conv_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    gray_conv_sched #(.N_REQ(4), .DW(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .req_data_i   (req_data),
        .req_ack_o    (ack),
        .conv_en_o    (conv_en),
        .conv_data_o  (conv_data),
        .conv_result_i(conv_result),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
        .rsp_data_o   (rsp_data),
        .busy_o       (busy)
    );

    assign conv_result = conv_data ^ (conv_data >> 1);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic [3:0]  q;
        logic [31:0] d;
        logic        y;
        logic [3:0]  a;
        logic [2:0]  e;
        logic [7:0]  c;
        logic        v;
        logic [2:0]  i;
        logic [7:0]  rd;
        logic        b;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic [3:0] q, logic [31:0] d, logic y, logic [3:0] a,
                                logic [2:0] e, logic [7:0] c, logic v, logic [2:0] i,
                                logic [7:0] rd, logic b);
        vec_t t;
        t.r = r; t.q = q; t.d = d; t.y = y; t.a = a; t.e = e;
        t.c = c; t.v = v; t.i = i; t.rd = rd; t.b = b;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic r, input logic [3:0] q, input logic [31:0] d,
                          input logic y);
        rst = r; req = q; req_data = d; rsp_ready = y;
        #1;
    endtask

    task automatic chk_all(input string p, input vec_t t);
        chk({p, " ack"},   32'(ack),       32'(t.a));
        chk({p, " en"},    32'(conv_en),   32'(t.e));
        chk({p, " cdata"}, 32'(conv_data), 32'(t.c));
        chk({p, " valid"}, 32'(rsp_valid), 32'(t.v));
        chk({p, " id"},    32'(rsp_id),    32'(t.i));
        chk({p, " rdata"}, 32'(rsp_data),  32'(t.rd));
        chk({p, " busy"},  32'(busy),      32'(t.b));
    endtask

    localparam logic [31:0] D4 = 32'h2A00_80FF;
    localparam logic [31:0] DA = 32'h0000_0500;

    logic [3:0] rot_ack [5];
    logic [2:0] rot_id  [5];

    initial begin
        rst = 1'b1; req = '0; req_data = '0; rsp_ready = 1'b0;
        tick();

        // Reset with all requests high, then single transaction on requester 1.
        vecs.push_back(mk(1, 4'b1111, D4, 1, 4'b0000, 3'b000, 8'h00, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 4'b0010, DA, 1, 4'b0010, 3'b000, 8'h00, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 4'b0000, DA, 1, 4'b0000, 3'b100, 8'h05, 0, 0, 8'h00, 1));
        vecs.push_back(mk(0, 4'b0000, DA, 1, 4'b0000, 3'b000, 8'h00, 1, 1, 8'h07, 1));
        vecs.push_back(mk(0, 4'b0000, DA, 1, 4'b0000, 3'b000, 8'h00, 0, 1, 8'h07, 0));
        // Reset clears ptr (was 2), then all four request: grant order 0,1,2,3.
        vecs.push_back(mk(1, 4'b0000, D4, 1, 4'b0000, 3'b000, 8'h00, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 4'b1111, D4, 1, 4'b0001, 3'b000, 8'h00, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 4'b1110, D4, 1, 4'b0000, 3'b100, 8'hFF, 0, 0, 8'h00, 1));
        vecs.push_back(mk(0, 4'b1110, D4, 1, 4'b0000, 3'b000, 8'h00, 1, 0, 8'h80, 1));
        vecs.push_back(mk(0, 4'b1110, D4, 1, 4'b0010, 3'b000, 8'h00, 0, 0, 8'h80, 0));
        vecs.push_back(mk(0, 4'b1100, D4, 1, 4'b0000, 3'b100, 8'h80, 0, 0, 8'h80, 1));
        vecs.push_back(mk(0, 4'b1100, D4, 1, 4'b0000, 3'b000, 8'h00, 1, 1, 8'hC0, 1));
        vecs.push_back(mk(0, 4'b1100, D4, 1, 4'b0100, 3'b000, 8'h00, 0, 1, 8'hC0, 0));
        vecs.push_back(mk(0, 4'b1000, D4, 1, 4'b0000, 3'b100, 8'h00, 0, 1, 8'hC0, 1));
        vecs.push_back(mk(0, 4'b1000, D4, 1, 4'b0000, 3'b000, 8'h00, 1, 2, 8'h00, 1));
        vecs.push_back(mk(0, 4'b1000, D4, 1, 4'b1000, 3'b000, 8'h00, 0, 2, 8'h00, 0));
        vecs.push_back(mk(0, 4'b0000, D4, 1, 4'b0000, 3'b100, 8'h2A, 0, 2, 8'h00, 1));
        vecs.push_back(mk(0, 4'b0000, D4, 1, 4'b0000, 3'b000, 8'h00, 1, 3, 8'h3F, 1));
        vecs.push_back(mk(0, 4'b0000, D4, 1, 4'b0000, 3'b000, 8'h00, 0, 3, 8'h3F, 0));

        foreach (vecs[n]) begin
            set_in(vecs[n].r, vecs[n].q, vecs[n].d, vecs[n].y);
            chk_all($sformatf("row%0d", n), vecs[n]);
            tick();
        end

        // Backpressure: response held 5 cycles, pending requests must not be acked.
        set_in(0, 4'b0001, 32'h00AA_0511, 0);
        chk("bp ack0", 32'(ack), 32'h1);
        tick();
        set_in(0, 4'b0010, 32'h00AA_0511, 0);
        chk("bp cdata", 32'(conv_data), 32'h11);
        chk("bp conv ack", 32'(ack), 32'h0);
        tick();
        for (int s = 0; s < 5; s++) begin
            set_in(0, (s < 2) ? 4'b0110 : 4'b0010, 32'h00AA_0511, 0);
            chk($sformatf("bp%0d valid", s), 32'(rsp_valid), 32'h1);
            chk($sformatf("bp%0d id", s),    32'(rsp_id),    32'h0);
            chk($sformatf("bp%0d rdata", s), 32'(rsp_data),  32'h19);
            chk($sformatf("bp%0d ack", s),   32'(ack),       32'h0);
            tick();
        end
        set_in(0, 4'b0010, 32'h00AA_0511, 1);
        chk("bp release valid", 32'(rsp_valid), 32'h1);
        tick();
        #1;
        chk("bp next ack", 32'(ack), 32'h2);
        chk("bp next busy", 32'(busy), 32'h0);
        tick();
        set_in(0, 4'b0000, 32'h00AA_0511, 1);
        chk("bp2 cdata", 32'(conv_data), 32'h05);
        tick();
        chk("bp2 id", 32'(rsp_id), 32'h1);
        chk("bp2 rdata", 32'(rsp_data), 32'h07);
        tick();
        chk("bp dropped busy", 32'(busy), 32'h0);
        chk("bp dropped ack", 32'(ack), 32'h0);

        // Reset asserted during CONV discards the grant; resume on requester 0.
        set_in(0, 4'b0100, 32'h00AA_0000, 1);
        chk("rc ack", 32'(ack), 32'h4);
        tick();
        chk("rc conv en", 32'(conv_en), 32'h4);
        set_in(1, 4'b0000, 32'h0, 1);
        chk_all("rc reset", mk(1, 0, 0, 1, 4'b0000, 3'b000, 8'h00, 0, 0, 8'h00, 0));
        tick();
        set_in(0, 4'b0001, 32'h0000_0003, 1);
        chk("rc resume ack", 32'(ack), 32'h1);
        tick();
        set_in(0, 4'b0000, 32'h0000_0003, 1);
        chk("rc cdata", 32'(conv_data), 32'h03);
        tick();
        chk("rc valid", 32'(rsp_valid), 32'h1);
        chk("rc rdata", 32'(rsp_data), 32'h02);
        chk("rc id", 32'(rsp_id), 32'h0);
        tick();

        // All four held high continuously.
`ifdef GRAY_SCHED_PRIO0_EN
        rot_ack = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        rot_id  = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
`else
        rot_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rot_id  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
`endif
        set_in(1, 4'b0000, D4, 1);
        tick();
        rst = 1'b0; req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            #1;
            chk($sformatf("rot%0d ack", t), 32'(ack), 32'(rot_ack[t]));
            tick();
            tick();
            chk($sformatf("rot%0d id", t), 32'(rsp_id), 32'(rot_id[t]));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
